sync_fifo_param: RTL

//  Parametrised single-clock FIFO; next generation of the 8x16 FIFO memory block.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram_2p.sv | 23 ++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and read-mode constants for the parametrised FIFO
package fifo_pkg;

    localparam int SA_REG  = 0;
    localparam int SA_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: DEPTH x DATA_W storage, synchronous write, asynchronous read
module fifo_ram_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // store the word on an accepted write; contents are never reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, programmable thresholds, flush and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4,
    parameter int SHOW_AHEAD = SA_FWFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW + 1)'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end
    if (DATA_W < 1) begin : g_bad_w
        $error("sync_fifo_param: DATA_W must be >= 1");
    end

    logic [AW:0]        wptr, rptr, cnt;
    logic [DATA_W-1:0]  ram_q, rd_q;
    logic               rd_acc, wr_acc;

    assign empty        = cnt == '0;
    assign full         = cnt == DEPTH_C;
    assign almost_full  = cnt >= AF_C;
    assign almost_empty = cnt <= AE_C;
    assign count        = cnt;

    // a full FIFO still takes a write when a read frees a slot in the same cycle
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_ram_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (wr_acc & ~flush),
        .waddr(wptr[AW-1:0]),
        .wdata(wr_data),
        .raddr(rptr[AW-1:0]),
        .rdata(ram_q)
    );

    // pointers and occupancy; flush empties the FIFO and ignores that cycle's requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wr_acc ? wptr + 1'b1 : wptr;
            rptr <= rd_acc ? rptr + 1'b1 : rptr;
            cnt  <= (wr_acc && !rd_acc) ? cnt + 1'b1 :
                    (rd_acc && !wr_acc) ? cnt - 1'b1 : cnt;
        end
    end

    // sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (~flush & wr_en & ~wr_acc) | (overflow & ~clr_err);
            underflow <= (~flush & rd_en & empty) | (underflow & ~clr_err);
        end
    end

    // registered read data, loaded only by an accepted pop and held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= '0;
        else if (rd_acc && !flush) rd_q <= ram_q;
    end

    assign rd_data = (SHOW_AHEAD != SA_REG) ? ram_q : rd_q;

endmodule
